parser_in_arb: RTL

- Packet-level round-robin arbiter that shares the single 32-bit parser input stream between N_SRC upstream packet sources.
- Holds the grant for a whole packet, from the first beat through the beat carrying last.
- Enforces a per-packet word limit: an over-long packet is truncated with a forced last, and its tail is drained, so the parser never sees an unterminated packet.
- Sits directly in front of the parser input port.

---
 rtl/parser_pkg.sv | 17 +
 rtl/parser_in_arb_if.sv | 39 +++
 rtl/parser_in_arb_rr_pick.sv | 31 +++
 rtl/parser_in_arb.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/parser_pkg.sv
// Shared definitions for the parser input path.
// Contents:
//   DATA_W      - default beat width of the parser input stream
//   HDR_BEATS   - number of header beats at the start of every packet
//   arb_state_e - packet arbiter state encoding
package parser_pkg;

    localparam int DATA_W    = 32;
    localparam int HDR_BEATS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/parser_in_arb_if.sv
// Handshake bundle between N_SRC upstream packet sources, the packet
// arbiter and the parser input port.
// Signals:
//   src_data  - source beats, source i at [i*DATA_W +: DATA_W]
//   src_val   - per-source beat valid
//   src_last  - per-source last-beat marker
//   src_ready - per-source ready (driven by the arbiter)
//   par_data  - beat to the parser
//   par_val   - valid to the parser
//   par_last  - last to the parser
//   par_ready - ready from the parser
// Modports:
//   master - arbiter view (drives src_ready and the par_* beat)
//   slave  - environment view (sources plus parser)
interface parser_in_arb_if #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = parser_pkg::DATA_W
);

    logic [N_SRC*DATA_W-1:0] src_data;
    logic [N_SRC-1:0]        src_val;
    logic [N_SRC-1:0]        src_last;
    logic [N_SRC-1:0]        src_ready;
    logic [DATA_W-1:0]       par_data;
    logic                    par_val;
    logic                    par_last;
    logic                    par_ready;

    modport master (
        input  src_data, src_val, src_last, par_ready,
        output src_ready, par_data, par_val, par_last
    );

    modport slave (
        output src_data, src_val, src_last, par_ready,
        input  src_ready, par_data, par_val, par_last
    );

endinterface

// File: rtl/parser_in_arb_rr_pick.sv
// Combinational round-robin priority select.
// Ports:
//   req  in  N_SRC  request vector
//   ptr  in  IDX_W  index of the most recent winner
//   pick out IDX_W  first requester strictly after ptr, wrapping modulo N_SRC
//   any  out 1      at least one request is present
module rr_pick #(
    parameter  int N_SRC = 4,
    localparam int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick,
    output logic             any
);

    logic [IDX_W-1:0] idx_s;

    // Scan the offsets farthest-first so the requester nearest after ptr
    // overwrites all others and wins; offset N_SRC is ptr itself (lowest).
    always_comb begin
        pick  = {IDX_W{1'b0}};
        idx_s = {IDX_W{1'b0}};
        any   = |req;
        for (int off = N_SRC; off >= 1; off--) begin
            idx_s = IDX_W'((int'(ptr) + off) % N_SRC);
            pick  = req[idx_s] ? idx_s : pick;
        end
    end

endmodule

// File: rtl/parser_in_arb.sv
// Packet-level round-robin arbiter in front of the parser input port.
// A source keeps the grant from its first beat through its last beat.
// Packets longer than MAX_WORDS beats are cut with a forced par_last and
// the remainder is swallowed, so the parser always sees terminated packets.
// Ports:
//   clk          in  1      clock, all logic on posedge
//   reset        in  1      synchronous active-high reset
//   bus          master    source and parser handshake bundle
//   grant_id     out IDX_W  currently granted source
//   busy         out 1      a packet is being passed or drained
//   overrun      out 1      one-cycle pulse when a packet is truncated
//   overrun_src  out IDX_W  source of the most recent truncation (sticky)
module parser_in_arb #(
    parameter  int N_SRC     = 4,
    parameter  int DATA_W    = parser_pkg::DATA_W,
    parameter  int MAX_WORDS = 64,
    localparam int IDX_W     = $clog2(N_SRC),
    localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    parser_in_arb_if.master  bus,
    output logic [IDX_W-1:0] grant_id,
    output logic             busy,
    output logic             overrun,
    output logic [IDX_W-1:0] overrun_src
);

    import parser_pkg::*;

    arb_state_e        state_r;
    logic [IDX_W-1:0]  rr_ptr_r;
    logic [IDX_W-1:0]  grant_r;
    logic [CNT_W-1:0]  word_cnt_r;
    logic              overrun_r;
    logic [IDX_W-1:0]  overrun_src_r;

    logic [IDX_W-1:0]  pick_s;
    logic              any_s;
    logic [DATA_W-1:0] g_data_s;
    logic              g_val_s;
    logic              g_last_s;
    logic              at_limit_s;
    logic              accept_s;
    logic [N_SRC-1:0]  ready_s;
    logic              par_val_s;
    logic              par_last_s;

    rr_pick #(.N_SRC(N_SRC)) u_rr_pick (
        .req  (bus.src_val),
        .ptr  (rr_ptr_r),
        .pick (pick_s),
        .any  (any_s)
    );

    // The beat being forwarded is the MAX_WORDS-th of this packet.
    assign at_limit_s = (word_cnt_r == CNT_W'(MAX_WORDS - 1));

    // Select the granted source's beat, valid and last.
    always_comb begin
        g_data_s = {DATA_W{1'b0}};
        g_val_s  = 1'b0;
        g_last_s = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            g_data_s = (grant_r == IDX_W'(i)) ? bus.src_data[i*DATA_W +: DATA_W] : g_data_s;
            g_val_s  = (grant_r == IDX_W'(i)) ? bus.src_val[i]  : g_val_s;
            g_last_s = (grant_r == IDX_W'(i)) ? bus.src_last[i] : g_last_s;
        end
    end

    // Handshake steering; everything is held off while reset is asserted.
    always_comb begin
        ready_s    = {N_SRC{1'b0}};
        par_val_s  = 1'b0;
        par_last_s = 1'b0;
        accept_s   = 1'b0;
        if (!reset) begin
            case (state_r)
                PASS: begin
                    par_val_s  = g_val_s;
                    par_last_s = g_last_s | at_limit_s;
                    accept_s   = g_val_s & bus.par_ready;
                    for (int i = 0; i < N_SRC; i++) begin
                        ready_s[i] = (grant_r == IDX_W'(i)) ? bus.par_ready : 1'b0;
                    end
                end
                DRAIN: begin
                    // Tail beats are consumed but never shown to the parser.
                    accept_s = g_val_s;
                    for (int i = 0; i < N_SRC; i++) begin
                        ready_s[i] = (grant_r == IDX_W'(i));
                    end
                end
                default: begin
                    ready_s = {N_SRC{1'b0}};
                end
            endcase
        end else begin
            ready_s = {N_SRC{1'b0}};
        end
    end

    assign bus.src_ready = ready_s;
    assign bus.par_data  = g_data_s;
    assign bus.par_val   = par_val_s;
    assign bus.par_last  = par_last_s;

    // Arbitration FSM, beat counter and overrun reporting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            rr_ptr_r      <= IDX_W'(N_SRC - 1);
            grant_r       <= {IDX_W{1'b0}};
            word_cnt_r    <= {CNT_W{1'b0}};
            overrun_r     <= 1'b0;
            overrun_src_r <= {IDX_W{1'b0}};
        end else begin
            overrun_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    word_cnt_r <= {CNT_W{1'b0}};
                    if (any_s) begin
                        grant_r  <= pick_s;
                        rr_ptr_r <= pick_s;
                        state_r  <= PASS;
                    end
                end
                PASS: begin
                    if (accept_s) begin
                        word_cnt_r <= word_cnt_r + CNT_W'(1);
                        // A genuine last on the limit beat ends cleanly.
                        if (g_last_s) begin
                            state_r <= IDLE;
                        end else if (at_limit_s) begin
                            overrun_r     <= 1'b1;
                            overrun_src_r <= grant_r;
                            state_r       <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (accept_s && g_last_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign grant_id    = grant_r;
    assign busy        = (state_r != IDLE);
    assign overrun     = overrun_r;
    assign overrun_src = overrun_src_r;

endmodule
